// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants: hazard FSM state encoding, multiply latency default, zero register.
package pipe_hazard_ctrl_pkg;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_WAIT = 1'b1;

  localparam int MUL_LAT_DEFAULT = 4;
  // Wide enough for MUL_LAT-2 at the largest legal latency (16).
  localparam int MUL_CNT_W       = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use comparator: flags an ID instruction reading the destination of a load sitting in EX.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_reg_dst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  // Writes to the zero register never produce a value worth waiting for.
  assign load_use = ex_mem_read && (ex_reg_dst != REG_ZERO) &&
                    ((ex_reg_dst == id_rs) || (id_uses_rt && (ex_reg_dst == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use stall, taken-branch flush, multi-cycle multiply hold.
// Outputs are combinational from current state and ID/EX fields; stall_count saturates.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  parameter int CNT_W   = 32
)
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       id_Rs,
  input  logic [4:0]       id_Rt,
  input  logic             id_uses_Rt,
  input  logic             id_is_mul,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_reg_Dst,
  input  logic             branch_taken,
  output logic             stall_PC,
  output logic             stall_IFID,
  output logic             hold_IDEX,
  output logic             bubble_IDEX,
  output logic             flush_IFID,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_count
);

  logic [0:0]           state;
  logic [MUL_CNT_W-1:0] mul_cnt;
  logic                 load_use;
  logic                 in_mul;
  logic                 mul_issue;

  load_use_detect u_load_use (
    .ex_mem_read (ex_MemRead),
    .ex_reg_dst  (ex_reg_Dst),
    .id_rs       (id_Rs),
    .id_rt       (id_Rt),
    .id_uses_rt  (id_uses_Rt),
    .load_use    (load_use)
  );

  assign in_mul    = (state == ST_MUL_WAIT);
  assign mul_issue = !in_mul && id_is_mul && !load_use && !branch_taken;

  // Priority: multiply in flight, then branch flush, then load-use stall.
  always_comb begin
    stall_PC    = 1'b0;
    stall_IFID  = 1'b0;
    hold_IDEX   = 1'b0;
    bubble_IDEX = 1'b0;
    flush_IFID  = 1'b0;
    mul_busy    = 1'b0;
    if (!Reset) begin
      if (in_mul) begin
        stall_PC   = 1'b1;
        stall_IFID = 1'b1;
        hold_IDEX  = 1'b1;
        mul_busy   = 1'b1;
      end else if (branch_taken) begin
        flush_IFID  = 1'b1;
        bubble_IDEX = 1'b1;
      end else if (load_use) begin
        stall_PC    = 1'b1;
        stall_IFID  = 1'b1;
        bubble_IDEX = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      mul_cnt     <= '0;
      stall_count <= '0;
    end else begin
      if (in_mul) begin
        if (mul_cnt == '0) begin
          state <= ST_IDLE;
        end else begin
          mul_cnt <= mul_cnt - MUL_CNT_W'(1);
        end
      end else if (mul_issue) begin
        state   <= ST_MUL_WAIT;
        mul_cnt <= MUL_CNT_W'(MUL_LAT - 2);
      end
      if (stall_PC && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, corner sequences, and a randomized run against a stall-budget model.
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  id_Rs, id_Rt, ex_reg_Dst;
  logic        id_uses_Rt, id_is_mul, ex_MemRead, branch_taken;

  logic        stall_PC, stall_IFID, hold_IDEX, bubble_IDEX, flush_IFID, mul_busy;
  logic [31:0] stall_count;
  logic        stall_PC_4, stall_IFID_4, hold_IDEX_4, bubble_IDEX_4, flush_IFID_4, mul_busy_4;
  logic [3:0]  stall_count_4;

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_uses_Rt(id_uses_Rt),
    .id_is_mul(id_is_mul), .ex_MemRead(ex_MemRead), .ex_reg_Dst(ex_reg_Dst),
    .branch_taken(branch_taken), .stall_PC(stall_PC), .stall_IFID(stall_IFID),
    .hold_IDEX(hold_IDEX), .bubble_IDEX(bubble_IDEX), .flush_IFID(flush_IFID),
    .mul_busy(mul_busy), .stall_count(stall_count)
  );

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_uses_Rt(id_uses_Rt),
    .id_is_mul(id_is_mul), .ex_MemRead(ex_MemRead), .ex_reg_Dst(ex_reg_Dst),
    .branch_taken(branch_taken), .stall_PC(stall_PC_4), .stall_IFID(stall_IFID_4),
    .hold_IDEX(hold_IDEX_4), .bubble_IDEX(bubble_IDEX_4), .flush_IFID(flush_IFID_4),
    .mul_busy(mul_busy_4), .stall_count(stall_count_4)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Output vector order: {stall_PC, stall_IFID, hold_IDEX, bubble_IDEX, flush_IFID, mul_busy}
  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b110100;
  localparam logic [5:0] O_BR   = 6'b000110;
  localparam logic [5:0] O_MUL  = 6'b111001;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       mul;
    logic       mr;
    logic [4:0] dst;
    logic       br;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {stall_PC, stall_IFID, hold_IDEX, bubble_IDEX, flush_IFID, mul_busy};
  endfunction

  function automatic logic [5:0] outs4();
    return {stall_PC_4, stall_IFID_4, hold_IDEX_4, bubble_IDEX_4, flush_IFID_4, mul_busy_4};
  endfunction

  task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mul, input logic mr, input logic [4:0] dst, input logic br);
    Reset = rst; id_Rs = rs; id_Rt = rt; id_uses_Rt = urt;
    id_is_mul = mul; ex_MemRead = mr; ex_reg_Dst = dst; branch_taken = br;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  // Model: remaining multiply stall cycles and saturating stall counts.
  int          rem;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt4;

  function automatic logic model_lu();
    return ex_MemRead && ex_reg_Dst != 5'd0 &&
           (ex_reg_Dst == id_Rs || (id_uses_Rt && ex_reg_Dst == id_Rt));
  endfunction

  function automatic logic [5:0] model_outs();
    if (Reset)        return O_NONE;
    if (rem > 0)      return O_MUL;
    if (branch_taken) return O_BR;
    if (model_lu())   return O_LU;
    return O_NONE;
  endfunction

  task automatic model_edge();
    logic stalled;
    if (Reset) begin
      rem = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      stalled = (rem > 0) || (!branch_taken && model_lu());
      if (stalled) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1;
      end
      if (rem > 0) rem = rem - 1;
      else if (id_is_mul && !model_lu() && !branch_taken) rem = MUL_LAT - 1;
    end
  endtask

  initial begin
    logic [31:0] exp_cnt;

    vecs[0]  = '{rs:8, rt:1, urt:0, mul:0, mr:1, dst:8, br:0, exp:O_LU};
    vecs[1]  = '{rs:0, rt:0, urt:1, mul:0, mr:1, dst:0, br:0, exp:O_NONE};
    vecs[2]  = '{rs:1, rt:9, urt:0, mul:0, mr:1, dst:9, br:0, exp:O_NONE};
    vecs[3]  = '{rs:1, rt:9, urt:1, mul:0, mr:1, dst:9, br:0, exp:O_LU};
    vecs[4]  = '{rs:8, rt:1, urt:0, mul:0, mr:0, dst:8, br:0, exp:O_NONE};
    vecs[5]  = '{rs:8, rt:1, urt:0, mul:0, mr:1, dst:8, br:1, exp:O_BR};
    vecs[6]  = '{rs:2, rt:3, urt:1, mul:0, mr:0, dst:4, br:1, exp:O_BR};
    vecs[7]  = '{rs:2, rt:3, urt:1, mul:1, mr:0, dst:4, br:1, exp:O_BR};
    vecs[8]  = '{rs:8, rt:1, urt:0, mul:1, mr:1, dst:8, br:0, exp:O_LU};
    vecs[9]  = '{rs:2, rt:3, urt:1, mul:0, mr:0, dst:0, br:0, exp:O_NONE};
    vecs[10] = '{rs:3, rt:3, urt:1, mul:0, mr:1, dst:3, br:0, exp:O_LU};
    vecs[11] = '{rs:4, rt:5, urt:1, mul:0, mr:1, dst:6, br:0, exp:O_NONE};

    // Reset with a load-use present: outputs forced low.
    drive(1, 8, 1, 0, 0, 1, 8, 0);
    @(negedge Clk);
    check("reset_outs", 32'(outs()), 32'(O_NONE));
    check("reset_cnt", stall_count, 0);
    next_cycle();

    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, vecs[i].rs, vecs[i].rt, vecs[i].urt, vecs[i].mul, vecs[i].mr, vecs[i].dst, vecs[i].br);
      @(negedge Clk);
      check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
      check($sformatf("vec%0d_cnt", i), stall_count, exp_cnt);
      if (vecs[i].exp[5]) exp_cnt++;
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    check("table_cnt_final", stall_count, exp_cnt);
    next_cycle();

    // Multiply: issue cycle unstalled, then MUL_LAT-1 busy cycles.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 1, 2, 1, 1, 0, 0, 0);
    @(negedge Clk);
    check("mul_issue_outs", 32'(outs()), 32'(O_NONE));
    next_cycle();
    drive(0, 8, 8, 1, 0, 1, 8, 1);
    for (int i = 0; i < MUL_LAT - 1; i++) begin
      @(negedge Clk);
      check($sformatf("mul_wait%0d_outs", i), 32'(outs()), 32'(O_MUL));
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    check("mul_done_outs", 32'(outs()), 32'(O_NONE));
    check("mul_done_cnt", stall_count, MUL_LAT - 1);
    next_cycle();

    // Reset on the second MUL_WAIT cycle.
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    check("mulrst_wait1_busy", 32'(mul_busy), 1);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    check("mulrst_rst_outs", 32'(outs()), 32'(O_NONE));
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    check("mulrst_after_outs", 32'(outs()), 32'(O_NONE));
    check("mulrst_after_cnt", stall_count, 0);
    next_cycle();
    @(negedge Clk);
    check("mulrst_idle_outs", 32'(outs()), 32'(O_NONE));
    next_cycle();

    // Saturation of the 4-bit counter under continuous load-use.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(0, 8, 0, 0, 0, 1, 8, 0);
    for (int i = 0; i < 20; i++) next_cycle();
    @(negedge Clk);
    check("sat_cnt4", 32'(stall_count_4), 32'hF);
    check("sat_cnt32", stall_count, 20);
    next_cycle();
    @(negedge Clk);
    check("sat_cnt4_hold", 32'(stall_count_4), 32'hF);
    check("sat_stall4", 32'(stall_PC_4), 1);
    next_cycle();

    // Randomized run against the model.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    rem = 0; m_cnt = 0; m_cnt4 = 0;
    next_cycle();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(63) == 0), 5'($urandom_range(3)), 5'($urandom_range(3)),
            1'($urandom_range(1)), ($urandom_range(7) == 0), 1'($urandom_range(1)),
            5'($urandom_range(3)), ($urandom_range(7) == 0));
      @(negedge Clk);
      check("rand_outs", 32'(outs()), 32'(model_outs()));
      check("rand_outs4", 32'(outs4()), 32'(model_outs()));
      check("rand_cnt", stall_count, m_cnt);
      check("rand_cnt4", 32'(stall_count_4), 32'(m_cnt4));
      model_edge();
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
